// File: rtl/ks_string_poly_if.sv
// ks_string_poly_if: control/audio bundle between the Karplus-Strong voice engine and its host.
interface ks_string_poly_if #(
  parameter int NUM_VOICES  = 4,
  parameter int MAX_LENGTH  = 256,
  parameter int DATA_WIDTH  = 8,
  parameter int DECAY_WIDTH = 8
);
  localparam int PW = $clog2(MAX_LENGTH) + 1;
  logic                         sample_tick_i;
  logic                         freeze_i;
  logic [NUM_VOICES-1:0]        pluck_i;
  logic [NUM_VOICES*PW-1:0]     period_i;
  logic [DECAY_WIDTH-1:0]       decay_i;
  logic signed [DATA_WIDTH-1:0] noise_i;
  logic signed [DATA_WIDTH-1:0] mix_o;
  logic                         mix_valid_o;
  logic                         busy_o;
  logic                         overrun_o;
  logic [NUM_VOICES-1:0]        voice_active_o;
  modport slave (
    input  sample_tick_i, freeze_i, pluck_i, period_i, decay_i, noise_i,
    output mix_o, mix_valid_o, busy_o, overrun_o, voice_active_o
  );
  modport master (
    output sample_tick_i, freeze_i, pluck_i, period_i, decay_i, noise_i,
    input  mix_o, mix_valid_o, busy_o, overrun_o, voice_active_o
  );
endinterface

// File: rtl/ks_string_poly.sv
// ks_string_poly: time-multiplexed polyphonic Karplus-Strong engine sharing one datapath and delay RAM.
module ks_string_poly #(
  parameter int NUM_VOICES  = 4,
  parameter int MAX_LENGTH  = 256,
  parameter int DATA_WIDTH  = 8,
  parameter int DECAY_WIDTH = 8
) (
  input logic clk_i,
  input logic rst_ni,
  ks_string_poly_if.slave bus
);
  localparam int PW = $clog2(MAX_LENGTH) + 1;
  localparam int VW = $clog2(NUM_VOICES);
  localparam int AW = $clog2(MAX_LENGTH);
  localparam int DW = DATA_WIDTH;
  localparam int CW = DECAY_WIDTH;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_MIX} state_t;
  state_t r_state, w_next;
  logic [VW-1:0] r_v;
  logic [AW-1:0] r_wptr [NUM_VOICES];
  logic signed [DW-1:0] r_prev [NUM_VOICES];
  logic [PW-1:0] r_burst [NUM_VOICES];
  logic [PW-1:0] r_zero [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_active, r_pend, r_pluck_q;
  logic signed [DW-1:0] r_mem [0:NUM_VOICES*MAX_LENGTH-1];
  logic signed [DW-1:0] r_rdata, r_y, r_mix;
  logic signed [DW+VW-1:0] r_acc;
  logic r_mix_valid, r_overrun;
  logic [PW-1:0] w_praw, w_p, w_wp1, w_zero_n;
  logic [VW+AW-1:0] w_addr;
  logic signed [DW:0] w_sum, w_avg;
  logic signed [DW+CW+1:0] w_prod;
  logic signed [DW-1:0] w_w;
  logic w_pluck, w_burst, w_tick;
  assign w_praw = bus.period_i[r_v*PW +: PW];
  assign w_p = (w_praw < PW'(2)) ? PW'(2) : (w_praw > PW'(MAX_LENGTH)) ? PW'(MAX_LENGTH) : w_praw;
  assign w_addr = {r_v, r_wptr[r_v]};
  assign w_wp1 = {1'b0, r_wptr[r_v]} + PW'(1);
  // One extra bit keeps the two-tap sum exact before halving.
  assign w_sum = {r_rdata[DW-1], r_rdata} + {r_prev[r_v][DW-1], r_prev[r_v]};
  assign w_avg = w_sum >>> 1;
  assign w_prod = (DW+CW+2)'(w_avg) * (DW+CW+2)'($signed({1'b0, bus.decay_i}));
  assign w_pluck = r_pend[r_v];
  assign w_burst = w_pluck || (r_burst[r_v] != '0);
  assign w_w = w_burst ? bus.noise_i : r_active[r_v] ? r_y : '0;
  assign w_zero_n = (w_w == '0) ? r_zero[r_v] + PW'(1) : '0;
  assign w_tick = bus.sample_tick_i && !bus.freeze_i;
  always_comb begin
    w_next = (r_state == S_IDLE) ? (w_tick ? S_RD : S_IDLE) :
             (r_state == S_RD)   ? S_CALC :
             (r_state == S_CALC) ? S_WR :
             (r_state == S_WR)   ? ((r_v == VW'(NUM_VOICES-1)) ? S_MIX : S_RD) : S_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_v <= '0;
      r_rdata <= '0;
      r_y <= '0;
      r_acc <= '0;
      r_mix <= '0;
      r_mix_valid <= 1'b0;
      r_overrun <= 1'b0;
      r_active <= '0;
      r_pend <= '0;
      r_pluck_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_wptr[i] <= '0;
        r_prev[i] <= '0;
        r_burst[i] <= '0;
        r_zero[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_pluck_q <= bus.pluck_i;
      r_pend <= (r_pend & ~((r_state == S_WR) ? (NUM_VOICES'(1) << r_v) : '0)) | (bus.pluck_i & ~r_pluck_q);
      r_overrun <= w_tick && (r_state != S_IDLE);
      r_mix_valid <= (r_state == S_MIX);
      if (r_state == S_RD) r_rdata <= r_mem[w_addr];
      if (r_state == S_CALC) r_y <= DW'(w_prod >>> CW);
      if (r_state == S_WR) begin
        r_v <= r_v + VW'(1);
        r_prev[r_v] <= r_rdata;
        r_acc <= r_acc + (DW+VW)'(w_w);
        r_wptr[r_v] <= (w_wp1 >= w_p) ? '0 : w_wp1[AW-1:0];
        if (w_pluck) begin
          r_burst[r_v] <= w_p - PW'(1);
          r_active[r_v] <= 1'b1;
          r_zero[r_v] <= '0;
        end else if (w_burst) begin
          r_burst[r_v] <= r_burst[r_v] - PW'(1);
        end else if (r_active[r_v]) begin
          r_zero[r_v] <= w_zero_n;
          if (w_zero_n >= w_p) r_active[r_v] <= 1'b0;
        end
      end
      if (r_state == S_MIX) begin
        r_mix <= DW'(r_acc >>> VW);
        r_acc <= '0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (r_state == S_WR) r_mem[w_addr] <= w_w;
  end
  assign bus.mix_o = r_mix;
  assign bus.mix_valid_o = r_mix_valid;
  assign bus.busy_o = (r_state != S_IDLE);
  assign bus.overrun_o = r_overrun;
  assign bus.voice_active_o = r_active;
endmodule
